// File: rtl/lut_config_loader_if.sv
`default_nettype none
// ============================================================================
// lut_config_loader_if : bitstream handshake + LUT config bus bundle. Rev 1.0
// ============================================================================
interface lut_config_loader_if #(
  parameter int NUM_LUTS = 8,
  parameter int CFG_W    = 33,
  parameter int CNT_W    = 8
);
  logic                bs_valid;
  logic                bs_data;
  logic                bs_ready;
  logic                cfg_abort;
  logic [NUM_LUTS-1:0] config_en;
  logic [CFG_W-1:0]    config_in;
  logic [NUM_LUTS-1:0] loaded;
  logic                all_loaded;
  logic                err_addr;
  logic [CNT_W-1:0]    frame_count;
`ifdef LUT_CFG_PARITY_EN
  logic                err_parity;
`endif

  modport master (
    input  bs_valid, bs_data, cfg_abort,
    output bs_ready, config_en, config_in, loaded, all_loaded, err_addr,
`ifdef LUT_CFG_PARITY_EN
    output err_parity,
`endif
    output frame_count
  );

  modport slave (
    output bs_valid, bs_data, cfg_abort,
    input  bs_ready, config_en, config_in, loaded, all_loaded, err_addr,
`ifdef LUT_CFG_PARITY_EN
    input  err_parity,
`endif
    input  frame_count
  );
endinterface
`default_nettype wire

// File: rtl/lut_config_loader.sv
`default_nettype none
// ============================================================================
// lut_config_loader : serial config stream -> one-hot per-LUT config frames.
// Macro LUT_CFG_PARITY_EN adds a trailing even-parity bit and err_parity. Rev 1.0
// ============================================================================
module lut_config_loader #(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2**INPUTS,
  parameter int CFG_W    = 2*MEM_SIZE+1,
  parameter int NUM_LUTS = 8,
  parameter int ADDR_W   = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1,
  parameter int CNT_W    = 8
) (
  input  wire logic           config_clk,
  input  wire logic           config_rst_n,
  lut_config_loader_if.master bus
);

  localparam int BCNT_W = $clog2(CFG_W+1);

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_DATA  = 2'd1,
    S_PAR   = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic [BCNT_W-1:0]   bcnt_q,     bcnt_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [CFG_W-1:0]    shift_q,    shift_d;
  logic [NUM_LUTS-1:0] en_q,       en_d;
  logic [CFG_W-1:0]    word_q,     word_d;
  logic [NUM_LUTS-1:0] loaded_q,   loaded_d;
  logic                all_q,      all_d;
  logic                err_addr_q, err_addr_d;
  logic [CNT_W-1:0]    fcnt_q,     fcnt_d;
`ifdef LUT_CFG_PARITY_EN
  logic                par_q,      par_d;
  logic                perr_q,     perr_d;
  logic                err_par_q,  err_par_d;
`endif

  logic                ready;
  logic                xfer;
  logic                addr_ok;
  logic [NUM_LUTS-1:0] onehot;

  // ready depends on state only, so bs_valid never reaches bs_ready
  assign ready   = (state_q != S_APPLY);
  assign xfer    = bus.bs_valid && ready;
  assign addr_ok = (int'(addr_q) < NUM_LUTS);
  assign onehot  = NUM_LUTS'(1) << addr_q;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    en_d       = '0;
    word_d     = word_q;
    loaded_d   = loaded_q;
    all_d      = &loaded_q;
    err_addr_d = err_addr_q;
    fcnt_d     = fcnt_q;
`ifdef LUT_CFG_PARITY_EN
    par_d      = par_q;
    perr_d     = perr_q;
    err_par_d  = err_par_q;
`endif

    unique case (state_q)
      S_ADDR: begin
        if (xfer) begin
          addr_d = (addr_q >> 1) | (ADDR_W'(bus.bs_data) << (ADDR_W - 1));
`ifdef LUT_CFG_PARITY_EN
          par_d  = par_q ^ bus.bs_data;
`endif
          if (bcnt_q == BCNT_W'(ADDR_W - 1)) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end else begin
            bcnt_d  = bcnt_q + BCNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d = {bus.bs_data, shift_q[CFG_W-1:1]};
`ifdef LUT_CFG_PARITY_EN
          par_d   = par_q ^ bus.bs_data;
`endif
          if (bcnt_q == BCNT_W'(CFG_W - 1)) begin
`ifdef LUT_CFG_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_APPLY;
`endif
            bcnt_d  = '0;
          end else begin
            bcnt_d  = bcnt_q + BCNT_W'(1);
          end
        end
      end
      S_PAR: begin
`ifdef LUT_CFG_PARITY_EN
        if (xfer) begin
          perr_d  = par_q ^ bus.bs_data;
          state_d = S_APPLY;
          bcnt_d  = '0;
        end
`else
        state_d = S_ADDR;
        bcnt_d  = '0;
`endif
      end
      S_APPLY: begin
        state_d = S_ADDR;
        bcnt_d  = '0;
        addr_d  = '0;
        shift_d = '0;
`ifdef LUT_CFG_PARITY_EN
        par_d   = 1'b0;
        perr_d  = 1'b0;
        if (perr_q) err_par_d = 1'b1; else
`endif
        if (addr_ok) begin
          en_d     = onehot;
          word_d   = shift_q;
          loaded_d = loaded_q | onehot;
          fcnt_d   = fcnt_q + CNT_W'(1);
        end else begin
          err_addr_d = 1'b1;
        end
      end
      default: begin
        state_d = S_ADDR;
        bcnt_d  = '0;
      end
    endcase

    // abort drops the frame in flight but keeps all history/sticky state
    if (bus.cfg_abort) begin
      state_d    = S_ADDR;
      bcnt_d     = '0;
      addr_d     = '0;
      shift_d    = '0;
      en_d       = '0;
      word_d     = word_q;
      loaded_d   = loaded_q;
      err_addr_d = err_addr_q;
      fcnt_d     = fcnt_q;
`ifdef LUT_CFG_PARITY_EN
      par_d      = 1'b0;
      perr_d     = 1'b0;
      err_par_d  = err_par_q;
`endif
    end
  end

  always_ff @(posedge config_clk) begin
    if (!config_rst_n) begin
      state_q    <= S_ADDR;
      bcnt_q     <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      en_q       <= '0;
      word_q     <= '0;
      loaded_q   <= '0;
      all_q      <= 1'b0;
      err_addr_q <= 1'b0;
      fcnt_q     <= '0;
`ifdef LUT_CFG_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      err_par_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      en_q       <= en_d;
      word_q     <= word_d;
      loaded_q   <= loaded_d;
      all_q      <= all_d;
      err_addr_q <= err_addr_d;
      fcnt_q     <= fcnt_d;
`ifdef LUT_CFG_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
      err_par_q  <= err_par_d;
`endif
    end
  end

  assign bus.bs_ready    = ready;
  assign bus.config_en   = en_q;
  assign bus.config_in   = word_q;
  assign bus.loaded      = loaded_q;
  assign bus.all_loaded  = all_q;
  assign bus.err_addr    = err_addr_q;
  assign bus.frame_count = fcnt_q;
`ifdef LUT_CFG_PARITY_EN
  assign bus.err_parity  = err_par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lut_config_loader.sv
`default_nettype none
// ============================================================================
// tb_lut_config_loader : randomized self-checking bench with a frame-level model. Rev 1.0
// ============================================================================
module tb_lut_config_loader;

  localparam int NL   = 8;
  localparam int CW   = 33;
  localparam int AW   = 3;
  localparam int CNTW = 8;
`ifdef LUT_CFG_PARITY_EN
  localparam int FLEN = AW + CW + 1;
`else
  localparam int FLEN = AW + CW;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  lut_config_loader_if #(.NUM_LUTS(NL), .CFG_W(CW), .CNT_W(CNTW)) bus ();

  lut_config_loader #(.INPUTS(4), .NUM_LUTS(NL), .CNT_W(CNTW)) dut (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model: expected strobes plus the accumulated LUT status.
  logic [NL-1:0] exp_en_q[$];
  logic [CW-1:0] exp_word_q[$];
  logic [NL-1:0] got_en_q[$];
  logic [CW-1:0] got_word_q[$];
  int            got_cyc_q[$];
  logic [NL-1:0] m_loaded;
  int            m_count;
  logic [CW-1:0] m_word;
  logic          m_err_par;

  always @(negedge clk) begin
    if (bus.config_en !== '0) begin
      got_en_q.push_back(bus.config_en);
      got_word_q.push_back(bus.config_in);
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic model_clear();
    m_loaded = '0; m_count = 0; m_word = '0; m_err_par = 1'b0;
    exp_en_q.delete(); exp_word_q.delete();
    got_en_q.delete(); got_word_q.delete(); got_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.bs_valid = 1'b0; bus.cfg_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  function automatic logic [CW-1:0] rand_word();
    return CW'({$urandom(), $urandom()});
  endfunction

  // mode: 0 continuous valid, 1 valid every other cycle, 2 random gaps.
  // abort_at >= 1 aborts once that many bits were accepted; abort_apply aborts in APPLY.
  task automatic send_frame(input int addr, input logic [CW-1:0] pay, input int mode,
                            input int abort_at, input bit bad_par, input bit abort_apply,
                            output int start_cyc);
    logic [63:0] b;
    logic        p;
    logic        v;
    logic        rdy;
    int          i;
    int          it;
    b = '0; p = 1'b0; i = 0; it = 0; start_cyc = -1;
    for (int k = 0; k < AW; k++) b[k] = addr[k];
    for (int k = 0; k < CW; k++) b[AW+k] = pay[k];
    for (int k = 0; k < AW + CW; k++) p = p ^ b[k];
    b[AW+CW] = p ^ bad_par;
    while (i < FLEN && it < 4*FLEN + 20) begin
      if (i == abort_at) begin
        bus.cfg_abort = 1'b1; bus.bs_valid = 1'b1; bus.bs_data = $urandom_range(0, 1);
        @(posedge clk); #1;
        bus.cfg_abort = 1'b0; bus.bs_valid = 1'b0;
        return;
      end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((it % 2) == 0) : ($urandom_range(0, 3) != 0);
      bus.bs_valid = v; bus.bs_data = b[i];
      @(negedge clk);
      rdy = bus.bs_ready;
      if (v && rdy && i == 0) start_cyc = cyc;
      @(posedge clk); #1;
      if (v && rdy) i++;
      it++;
    end
    bus.bs_valid = 1'b0;
    if (i < FLEN) begin
      n_assert++; n_fail++;
      $display("FAIL frame_timeout: accepted %0d bits, expected %0d", i, FLEN);
      return;
    end
    if (abort_apply) begin
      bus.cfg_abort = 1'b1;
      @(posedge clk); #1;
      bus.cfg_abort = 1'b0;
      return;
    end
`ifdef LUT_CFG_PARITY_EN
    if (bad_par) m_err_par = 1'b1; else
`endif
    begin
      exp_en_q.push_back(NL'(1) << addr);
      exp_word_q.push_back(pay);
      m_loaded[addr] = 1'b1;
      m_count++;
      m_word = pay;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert += 6;
    if (bus.config_en !== '0)  begin n_fail++; $display("FAIL rst_en: got %h expected 0", bus.config_en); end
    if (bus.config_in !== '0)  begin n_fail++; $display("FAIL rst_cfg_in: got %h expected 0", bus.config_in); end
    if (bus.loaded !== '0)     begin n_fail++; $display("FAIL rst_loaded: got %h expected 0", bus.loaded); end
    if (bus.all_loaded !== 0)  begin n_fail++; $display("FAIL rst_all_loaded: got %b expected 0", bus.all_loaded); end
    if (bus.err_addr !== 0)    begin n_fail++; $display("FAIL rst_err_addr: got %b expected 0", bus.err_addr); end
    if (bus.frame_count !== 0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", bus.frame_count); end
`ifdef LUT_CFG_PARITY_EN
    n_assert++;
    if (bus.err_parity !== 0)  begin n_fail++; $display("FAIL rst_err_parity: got %b expected 0", bus.err_parity); end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    if (bus.bs_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", bus.bs_ready); end
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic test_single_frame();
    int sc;
    logic [NL-1:0] ge, ee;
    logic [CW-1:0] gw, ew;
    send_frame(3, 33'h1_A5A5_0F0F, 0, -1, 1'b0, 1'b0, sc);
    repeat (3) @(posedge clk); #1;
    n_assert++;
    if (got_cyc_q.size() == 0 || got_cyc_q[0] - sc != FLEN + 1) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected %0d", (got_cyc_q.size() == 0) ? -1 : got_cyc_q[0] - sc, FLEN + 1);
    end
    n_assert += 3;
    if (bus.config_in !== 33'h1_A5A5_0F0F) begin n_fail++; $display("FAIL single_cfg_in: got %h expected 1a5a50f0f", bus.config_in); end
    if (bus.loaded !== 8'h08)              begin n_fail++; $display("FAIL single_loaded: got %h expected 08", bus.loaded); end
    if (bus.frame_count !== 8'd1)          begin n_fail++; $display("FAIL single_count: got %0d expected 1", bus.frame_count); end
    while (got_en_q.size() > 0) begin
      ge = got_en_q.pop_front(); gw = got_word_q.pop_front(); void'(got_cyc_q.pop_front());
      n_assert++;
      if (exp_en_q.size() == 0) begin n_fail++; $display("FAIL single_extra_strobe: got en=%h expected none", ge); end
      else begin
        ee = exp_en_q.pop_front(); ew = exp_word_q.pop_front();
        if (ge !== ee || gw !== ew) begin n_fail++; $display("FAIL single_strobe: got %h/%h expected %h/%h", ge, gw, ee, ew); end
      end
    end
    n_assert++;
    if (exp_en_q.size() != 0) begin n_fail++; $display("FAIL single_missing: got %0d unseen strobes expected 0", exp_en_q.size()); end
  endtask

  task automatic test_eight_frames();
    int sc;
    logic [NL-1:0] ge, ee;
    logic [CW-1:0] gw, ew;
    do_reset();
    for (int a = 0; a < NL; a++) send_frame(a, rand_word(), 1, -1, 1'b0, 1'b0, sc);
    @(negedge clk);
    @(negedge clk);
    n_assert += 2;
    if (bus.config_en !== 8'h80) begin n_fail++; $display("FAIL eight_last_en: got %h expected 80", bus.config_en); end
    if (bus.all_loaded !== 1'b0) begin n_fail++; $display("FAIL eight_all_early: got %b expected 0", bus.all_loaded); end
    @(negedge clk);
    n_assert += 2;
    if (bus.all_loaded !== 1'b1) begin n_fail++; $display("FAIL eight_all_loaded: got %b expected 1", bus.all_loaded); end
    if (bus.config_en !== '0)    begin n_fail++; $display("FAIL eight_en_width: got %h expected 0", bus.config_en); end
    @(posedge clk); #1;
    n_assert++;
    if (bus.frame_count !== CNTW'(m_count)) begin n_fail++; $display("FAIL eight_count: got %0d expected %0d", bus.frame_count, m_count); end
    while (got_en_q.size() > 0) begin
      ge = got_en_q.pop_front(); gw = got_word_q.pop_front(); void'(got_cyc_q.pop_front());
      n_assert++;
      if (exp_en_q.size() == 0) begin n_fail++; $display("FAIL eight_extra_strobe: got en=%h expected none", ge); end
      else begin
        ee = exp_en_q.pop_front(); ew = exp_word_q.pop_front();
        if (ge !== ee || gw !== ew) begin n_fail++; $display("FAIL eight_strobe: got %h/%h expected %h/%h", ge, gw, ee, ew); end
      end
    end
    n_assert++;
    if (exp_en_q.size() != 0) begin n_fail++; $display("FAIL eight_missing: got %0d unseen strobes expected 0", exp_en_q.size()); end
  endtask

  task automatic test_abort();
    int sc;
    logic [NL-1:0] ge, ee;
    logic [CW-1:0] gw, ew;
    do_reset();
    send_frame(int'($urandom_range(0, NL-1)), rand_word(), 0, 20, 1'b0, 1'b0, sc);
    send_frame(5, '0, 0, -1, 1'b0, 1'b0, sc);
    repeat (3) @(posedge clk); #1;
    n_assert += 2;
    if (bus.loaded !== 8'h20)  begin n_fail++; $display("FAIL abort_loaded: got %h expected 20", bus.loaded); end
    if (bus.config_in !== '0)  begin n_fail++; $display("FAIL abort_cfg_in: got %h expected 0", bus.config_in); end
    send_frame(6, rand_word(), 0, -1, 1'b0, 1'b1, sc);
    repeat (3) @(posedge clk); #1;
    n_assert += 2;
    if (bus.loaded !== 8'h20)      begin n_fail++; $display("FAIL abort_apply_loaded: got %h expected 20", bus.loaded); end
    if (bus.frame_count !== 8'd1)  begin n_fail++; $display("FAIL abort_apply_count: got %0d expected 1", bus.frame_count); end
    while (got_en_q.size() > 0) begin
      ge = got_en_q.pop_front(); gw = got_word_q.pop_front(); void'(got_cyc_q.pop_front());
      n_assert++;
      if (exp_en_q.size() == 0) begin n_fail++; $display("FAIL abort_extra_strobe: got en=%h expected none", ge); end
      else begin
        ee = exp_en_q.pop_front(); ew = exp_word_q.pop_front();
        if (ge !== ee || gw !== ew) begin n_fail++; $display("FAIL abort_strobe: got %h/%h expected %h/%h", ge, gw, ee, ew); end
      end
    end
    n_assert++;
    if (exp_en_q.size() != 0) begin n_fail++; $display("FAIL abort_missing: got %0d unseen strobes expected 0", exp_en_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int sc;
    logic [CW-1:0] pay;
    logic [NL-1:0] ge, ee;
    logic [CW-1:0] gw, ew;
    do_reset();
    send_frame(2, rand_word(), 0, -1, 1'b0, 1'b0, sc);
    bus.bs_valid = 1'b1;
    for (int k = 0; k < AW + 10; k++) begin
      bus.bs_data = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.bs_valid = 1'b0;
    @(negedge clk);
    n_assert += 4;
    if (bus.config_en !== '0)  begin n_fail++; $display("FAIL midrst_en: got %h expected 0", bus.config_en); end
    if (bus.config_in !== '0)  begin n_fail++; $display("FAIL midrst_cfg_in: got %h expected 0", bus.config_in); end
    if (bus.loaded !== '0)     begin n_fail++; $display("FAIL midrst_loaded: got %h expected 0", bus.loaded); end
    if (bus.frame_count !== 0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", bus.frame_count); end
    @(posedge clk); #1;
    model_clear();
    pay = rand_word();
    send_frame(2, pay, 0, -1, 1'b0, 1'b0, sc);
    repeat (3) @(posedge clk); #1;
    n_assert += 2;
    if (bus.loaded !== 8'h04)  begin n_fail++; $display("FAIL midrst_reload: got %h expected 04", bus.loaded); end
    if (bus.config_in !== pay) begin n_fail++; $display("FAIL midrst_cfg_word: got %h expected %h", bus.config_in, pay); end
    while (got_en_q.size() > 0) begin
      ge = got_en_q.pop_front(); gw = got_word_q.pop_front(); void'(got_cyc_q.pop_front());
      n_assert++;
      if (exp_en_q.size() == 0) begin n_fail++; $display("FAIL midrst_extra_strobe: got en=%h expected none", ge); end
      else begin
        ee = exp_en_q.pop_front(); ew = exp_word_q.pop_front();
        if (ge !== ee || gw !== ew) begin n_fail++; $display("FAIL midrst_strobe: got %h/%h expected %h/%h", ge, gw, ee, ew); end
      end
    end
    n_assert++;
    if (exp_en_q.size() != 0) begin n_fail++; $display("FAIL midrst_missing: got %0d unseen strobes expected 0", exp_en_q.size()); end
  endtask

  task automatic test_wrap();
    int sc;
    logic [NL-1:0] ge, ee;
    logic [CW-1:0] gw, ew;
    do_reset();
    for (int f = 0; f < 256; f++) send_frame(f % NL, rand_word(), 0, -1, 1'b0, 1'b0, sc);
    repeat (3) @(posedge clk); #1;
    n_assert += 2;
    if (bus.frame_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", bus.frame_count); end
    if (bus.loaded !== 8'hFF)     begin n_fail++; $display("FAIL wrap_loaded: got %h expected ff", bus.loaded); end
    send_frame(int'($urandom_range(0, NL-1)), rand_word(), 0, -1, 1'b0, 1'b0, sc);
    repeat (3) @(posedge clk); #1;
    n_assert++;
    if (bus.frame_count !== 8'd1) begin n_fail++; $display("FAIL wrap_one: got %0d expected 1", bus.frame_count); end
    while (got_en_q.size() > 0) begin
      ge = got_en_q.pop_front(); gw = got_word_q.pop_front(); void'(got_cyc_q.pop_front());
      n_assert++;
      if (exp_en_q.size() == 0) begin n_fail++; $display("FAIL wrap_extra_strobe: got en=%h expected none", ge); end
      else begin
        ee = exp_en_q.pop_front(); ew = exp_word_q.pop_front();
        if (ge !== ee || gw !== ew) begin n_fail++; $display("FAIL wrap_strobe: got %h/%h expected %h/%h", ge, gw, ee, ew); end
      end
    end
    n_assert++;
    if (exp_en_q.size() != 0) begin n_fail++; $display("FAIL wrap_missing: got %0d unseen strobes expected 0", exp_en_q.size()); end
  endtask

  task automatic test_random();
    int  sc;
    int  ab;
    bit  aa;
    bit  bp;
    logic [NL-1:0] ge, ee;
    logic [CW-1:0] gw, ew;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, FLEN-1)) : -1;
      aa = (ab < 0) && ($urandom_range(0, 7) == 0);
`ifdef LUT_CFG_PARITY_EN
      bp = ($urandom_range(0, 5) == 0);
`else
      bp = 1'b0;
`endif
      send_frame(int'($urandom_range(0, NL-1)), rand_word(), 2, ab, bp, aa, sc);
    end
    repeat (3) @(posedge clk); #1;
    n_assert += 5;
    if (bus.loaded !== m_loaded)             begin n_fail++; $display("FAIL rand_loaded: got %h expected %h", bus.loaded, m_loaded); end
    if (bus.frame_count !== CNTW'(m_count))  begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", bus.frame_count, m_count % 256); end
    if (bus.config_in !== m_word)            begin n_fail++; $display("FAIL rand_cfg_in: got %h expected %h", bus.config_in, m_word); end
    if (bus.all_loaded !== (&m_loaded))      begin n_fail++; $display("FAIL rand_all_loaded: got %b expected %b", bus.all_loaded, &m_loaded); end
    if (bus.err_addr !== 1'b0)               begin n_fail++; $display("FAIL rand_err_addr: got %b expected 0", bus.err_addr); end
`ifdef LUT_CFG_PARITY_EN
    n_assert++;
    if (bus.err_parity !== m_err_par)        begin n_fail++; $display("FAIL rand_err_parity: got %b expected %b", bus.err_parity, m_err_par); end
`endif
    while (got_en_q.size() > 0) begin
      ge = got_en_q.pop_front(); gw = got_word_q.pop_front(); void'(got_cyc_q.pop_front());
      n_assert++;
      if (exp_en_q.size() == 0) begin n_fail++; $display("FAIL rand_extra_strobe: got en=%h expected none", ge); end
      else begin
        ee = exp_en_q.pop_front(); ew = exp_word_q.pop_front();
        if (ge !== ee || gw !== ew) begin n_fail++; $display("FAIL rand_strobe: got %h/%h expected %h/%h", ge, gw, ee, ew); end
      end
    end
    n_assert++;
    if (exp_en_q.size() != 0) begin n_fail++; $display("FAIL rand_missing: got %0d unseen strobes expected 0", exp_en_q.size()); end
  endtask

`ifdef LUT_CFG_PARITY_EN
  task automatic test_parity();
    int sc;
    logic [NL-1:0] ge, ee;
    logic [CW-1:0] gw, ew;
    do_reset();
    send_frame(1, rand_word(), 0, -1, 1'b1, 1'b0, sc);
    repeat (3) @(posedge clk); #1;
    n_assert += 4;
    if (bus.err_parity !== 1'b1) begin n_fail++; $display("FAIL par_err: got %b expected 1", bus.err_parity); end
    if (bus.loaded !== '0)       begin n_fail++; $display("FAIL par_loaded: got %h expected 0", bus.loaded); end
    if (bus.frame_count !== 0)   begin n_fail++; $display("FAIL par_count: got %0d expected 0", bus.frame_count); end
    if (got_en_q.size() != 0)    begin n_fail++; $display("FAIL par_strobe: got %0d strobes expected 0", got_en_q.size()); end
    send_frame(1, rand_word(), 0, -1, 1'b0, 1'b0, sc);
    repeat (3) @(posedge clk); #1;
    n_assert++;
    if (bus.loaded !== 8'h02)    begin n_fail++; $display("FAIL par_resend_loaded: got %h expected 02", bus.loaded); end
    while (got_en_q.size() > 0) begin
      ge = got_en_q.pop_front(); gw = got_word_q.pop_front(); void'(got_cyc_q.pop_front());
      n_assert++;
      if (exp_en_q.size() == 0) begin n_fail++; $display("FAIL par_extra_strobe: got en=%h expected none", ge); end
      else begin
        ee = exp_en_q.pop_front(); ew = exp_word_q.pop_front();
        if (ge !== ee || gw !== ew) begin n_fail++; $display("FAIL par_resend_strobe: got %h/%h expected %h/%h", ge, gw, ee, ew); end
      end
    end
    n_assert++;
    if (exp_en_q.size() != 0) begin n_fail++; $display("FAIL par_missing: got %0d unseen strobes expected 0", exp_en_q.size()); end
  endtask
`endif

  initial begin
    bus.bs_valid  = 1'b0;
    bus.bs_data   = 1'b0;
    bus.cfg_abort = 1'b0;
    model_clear();
    test_reset();
    test_single_frame();
    test_eight_frames();
    test_abort();
    test_reset_mid_frame();
    test_wrap();
    test_random();
`ifdef LUT_CFG_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
